rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_SIZE_BIT, default 3, log2 of entry count (8 entries); ROB_SIZE = 2**ROB_SIZE_BIT.
REQ-002 clk_in  input  1  system clock; the block uses this single clock.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  ready; low pauses the block.
REQ-005 flush_in  input  1  discard all entries (mispredict).
REQ-006 rob_full  output  1  no free entry.
REQ-007 rob_free_id  output  ROB_SIZE_BIT  ROB id the next issued instruction receives (tail).
REQ-008 issue_valid  input  1  Decoder issues an instruction.
REQ-009 issue_rd  input  5  destination register.
REQ-010 issue_ready  input  1  result already known at issue.
REQ-011 issue_value  input  32  result when issue_ready=1.
REQ-012 cdb_valid  input  1  CDB broadcast valid (RS result).
REQ-013 cdb_rob_id  input  ROB_SIZE_BIT  producing ROB id.
REQ-014 cdb_value  input  32  broadcast result.
REQ-015 q1_id / q2_id  input  ROB_SIZE_BIT  operand lookup ids from Decoder.
REQ-016 q1_ready / q2_ready  output  1  lookup result available.
REQ-017 q1_value / q2_value  output  32  lookup value.
REQ-018 commit_valid  output  1  one-cycle commit pulse to register file.
REQ-019 commit_rd  output  5; commit_value  output  32; commit_rob_id  output  ROB_SIZE_BIT  committed entry data.

Function
REQ-020 Entries form a circular buffer: head, tail (ROB_SIZE_BIT, wrap modulo ROB_SIZE), count (ROB_SIZE_BIT+1 bits).
REQ-021 rob_full = (count == ROB_SIZE), combinational from registered count; rob_free_id = tail.
REQ-022 Issue accepted at an edge when issue_valid && !rob_full && rdy_in: entry[tail] <= busy=1, ready=issue_ready, rd, value; tail increments.
REQ-023 issue_valid while rob_full is ignored; no state change.
REQ-024 CDB write at an edge when cdb_valid && rdy_in && entry[cdb_rob_id].busy: ready<=1, value<=cdb_value; writes to non-busy entries ignored.
REQ-025 Commit: at an edge with rdy_in, if entry[head] busy and ready, commit_valid<=1, commit_rd/value/rob_id <= entry data, entry busy<=0, head increments; else commit_valid<=0.
REQ-026 At most one commit per cycle; in-order only; CDB write at edge E to head entry yields commit_valid high in cycle after edge E+1.
REQ-027 Issue and commit on the same edge leave count unchanged; full-with-commit still rejects that cycle's issue.
REQ-028 Lookup combinational: qN_ready=1, qN_value=cdb_value if cdb_valid && cdb_rob_id==qN_id; else entry[qN_id].ready and .value.
REQ-029 rdy_in low: all state held, commit_valid cleared at each edge (no repeated commit).
REQ-030 flush_in high at an edge (regardless of rdy_in): all busy cleared, head=tail=count=0, commit_valid=0; flush dominates same-edge issue, CDB and commit.

Reset
REQ-031 rst_in low asynchronously: head=tail=count=0, all busy/ready=0, entry values 0, commit_valid=0, commit_rd=0, commit_value=0, commit_rob_id=0.
REQ-032 Consequently rob_full=0 and rob_free_id=0 during and after reset; reset mid-operation discards all entries.

Structure
REQ-033 ROB_SIZE, ROB_SIZE_BIT shared with RS and Decoder in Config.v; no local redefinition.
REQ-034 Single flat module; no sub-module required.

Verification
REQ-035 Issue 8 entries with issue_ready=0 -> rob_full=1, ninth issue ignored, rob_free_id=0.
REQ-036 Issue rd=5 issue_ready=1 value 0x1234 -> commit_valid pulse, commit_rd=5, commit_value=0x1234, commit_rob_id=0.
REQ-037 Issue ids 0,1 unready; CDB id1=0xBB then id0=0xAA -> commits id0 (0xAA) then id1 (0xBB), in order.
REQ-038 cdb_valid id=2 value 0x55 with q1_id=2 same cycle -> q1_ready=1, q1_value=0x55.
REQ-039 Full buffer, flush_in plus issue_valid same edge -> count 0, rob_full=0, rob_free_id=0, no commit.
REQ-040 rdy_in low for 3 cycles with ready head -> no commit_valid until rdy_in returns, then exactly one pulse.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared reorder-buffer configuration: entry count and field widths used by
// the ROB and its RS/Decoder neighbours.
package rob_pkg;

  localparam int CFG_ROB_SIZE_BIT = 3;
  localparam int RD_W             = 5;
  localparam int DATA_W           = 32;

  typedef logic [RD_W-1:0]   rob_rd_t;
  typedef logic [DATA_W-1:0] rob_data_t;

  function automatic int rob_depth(input int size_bit);
    return 1 << size_bit;
  endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: circular in-order retirement queue with CDB result capture
// and combinational operand lookup (with same-cycle CDB bypass).
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE_BIT = CFG_ROB_SIZE_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  output logic                    rob_full,
  output logic [ROB_SIZE_BIT-1:0] rob_free_id,
  input  logic                    issue_valid,
  input  rob_rd_t                 issue_rd,
  input  logic                    issue_ready,
  input  rob_data_t               issue_value,
  input  logic                    cdb_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_rob_id,
  input  rob_data_t               cdb_value,
  input  logic [ROB_SIZE_BIT-1:0] q1_id,
  input  logic [ROB_SIZE_BIT-1:0] q2_id,
  output logic                    q1_ready,
  output rob_data_t               q1_value,
  output logic                    q2_ready,
  output rob_data_t               q2_value,
  output logic                    commit_valid,
  output rob_rd_t                 commit_rd,
  output rob_data_t               commit_value,
  output logic [ROB_SIZE_BIT-1:0] commit_rob_id
);

  localparam int ROB_SIZE = rob_depth(ROB_SIZE_BIT);
  localparam int CNT_W    = ROB_SIZE_BIT + 1;

  logic      ent_busy  [ROB_SIZE];
  logic      ent_ready [ROB_SIZE];
  rob_rd_t   ent_rd    [ROB_SIZE];
  rob_data_t ent_value [ROB_SIZE];

  logic [ROB_SIZE_BIT-1:0] head;
  logic [ROB_SIZE_BIT-1:0] tail;
  logic [CNT_W-1:0]        count;

  logic issue_fire;
  logic commit_fire;
  logic cdb_fire;

  assign rob_full    = (count == CNT_W'(ROB_SIZE));
  assign rob_free_id = tail;

  assign issue_fire  = issue_valid && !rob_full && rdy_in;
  assign commit_fire = rdy_in && ent_busy[head] && ent_ready[head];
  assign cdb_fire    = cdb_valid && rdy_in && ent_busy[cdb_rob_id];

  // CDB bypass lets the decoder see a result in the same cycle it is broadcast.
  always_comb begin
    q1_ready = ent_ready[q1_id];
    q1_value = ent_value[q1_id];
    q2_ready = ent_ready[q2_id];
    q2_value = ent_value[q2_id];
    if (cdb_valid && cdb_rob_id == q1_id) begin
      q1_ready = 1'b1;
      q1_value = cdb_value;
    end
    if (cdb_valid && cdb_rob_id == q2_id) begin
      q2_ready = 1'b1;
      q2_value = cdb_value;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_busy[i]  <= 1'b0;
        ent_ready[i] <= 1'b0;
        ent_rd[i]    <= '0;
        ent_value[i] <= '0;
      end
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_valid  <= 1'b0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_rob_id <= '0;
    end else if (flush_in) begin
      for (int i = 0; i < ROB_SIZE; i++) ent_busy[i] <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
    end else if (!rdy_in) begin
      commit_valid <= 1'b0;
    end else begin
      if (cdb_fire) begin
        ent_ready[cdb_rob_id] <= 1'b1;
        ent_value[cdb_rob_id] <= cdb_value;
      end
      // Commit data is the pre-edge head content; a same-edge CDB write to a
      // head that is already ready does not alter what retires.
      if (commit_fire) begin
        commit_valid   <= 1'b1;
        commit_rd      <= ent_rd[head];
        commit_value   <= ent_value[head];
        commit_rob_id  <= head;
        ent_busy[head] <= 1'b0;
        head           <= head + ROB_SIZE_BIT'(1);
      end else begin
        commit_valid <= 1'b0;
      end
      if (issue_fire) begin
        ent_busy[tail]  <= 1'b1;
        ent_ready[tail] <= issue_ready;
        ent_rd[tail]    <= issue_rd;
        ent_value[tail] <= issue_value;
        tail            <= tail + ROB_SIZE_BIT'(1);
      end
      case ({issue_fire, commit_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rob;

  localparam int RB = 3;
  localparam int RS = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          flush_in;
  logic          rob_full;
  logic [RB-1:0] rob_free_id;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_ready;
  logic [31:0]   issue_value;
  logic          cdb_valid;
  logic [RB-1:0] cdb_rob_id;
  logic [31:0]   cdb_value;
  logic [RB-1:0] q1_id, q2_id;
  logic          q1_ready, q2_ready;
  logic [31:0]   q1_value, q2_value;
  logic          commit_valid;
  logic [4:0]    commit_rd;
  logic [31:0]   commit_value;
  logic [RB-1:0] commit_rob_id;

  int checks = 0;
  int errors = 0;

  rob #(.ROB_SIZE_BIT(RB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .rob_full(rob_full), .rob_free_id(rob_free_id),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .issue_value(issue_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q1_value(q1_value),
    .q2_ready(q2_ready), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_rob_id(commit_rob_id)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: in-flight instructions as an ordered queue; per-id
  // last-written ready/value kept separately because lookups may read stale ids.
  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic        rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  logic        m_ready [RS];
  logic [31:0] m_value [RS];
  logic        e_cv;
  logic [4:0]  e_rd;
  logic [31:0] e_val;
  int          e_id;

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    e_cv   = 1'b0;
    for (int i = 0; i < RS; i++) begin
      m_ready[i] = 1'b0;
      m_value[i] = '0;
    end
  endtask

  task automatic model_edge();
    bit full, do_commit;
    full = (mq.size() == RS);
    if (flush_in) begin
      mq.delete();
      m_tail = 0;
      e_cv   = 1'b0;
      return;
    end
    if (!rdy_in) begin
      e_cv = 1'b0;
      return;
    end
    do_commit = (mq.size() > 0) && mq[0].rdy;
    if (do_commit) begin
      e_rd  = mq[0].rd;
      e_val = mq[0].val;
      e_id  = mq[0].id;
    end
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (mq[i].id == int'(cdb_rob_id)) begin
          mq[i].rdy = 1'b1;
          mq[i].val = cdb_value;
          m_ready[cdb_rob_id] = 1'b1;
          m_value[cdb_rob_id] = cdb_value;
        end
      end
    end
    e_cv = do_commit;
    if (do_commit) void'(mq.pop_front());
    if (issue_valid && !full) begin
      mq.push_back('{id: m_tail, rd: issue_rd, rdy: issue_ready, val: issue_value});
      m_ready[m_tail] = issue_ready;
      m_value[m_tail] = issue_value;
      m_tail = (m_tail + 1) % RS;
    end
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; flush_in = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_ready = 1'b0; issue_value = '0;
    cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0;
    q1_id = '0; q2_id = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue_one(input logic [4:0] rd, input logic rdy, input logic [31:0] val);
    idle_inputs();
    issue_valid = 1'b1; issue_rd = rd; issue_ready = rdy; issue_value = val;
    tick();
    idle_inputs();
  endtask

  task automatic do_flush();
    idle_inputs();
    flush_in = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b0;
    model_reset();
    #12 rst_in = 1'b1;
    @(posedge clk_in); #1;
    issue_one(5'd3, 1'b1, 32'hDEAD_BEEF);
    issue_one(5'd4, 1'b1, 32'h1111_2222);
    #2 rst_in = 1'b0;
    model_reset();
    #1;
    checks++;
    if (commit_valid !== 1'b0 || commit_rd !== 5'd0 || commit_value !== 32'd0 || commit_rob_id !== '0) begin
      errors++;
      $display("FAIL reset_commit: got v=%b rd=%0d val=%h id=%0d want all 0",
               commit_valid, commit_rd, commit_value, commit_rob_id);
    end
    checks++;
    if (rob_full !== 1'b0 || rob_free_id !== '0) begin
      errors++;
      $display("FAIL reset_ptr: got full=%b free=%0d want 0 0", rob_full, rob_free_id);
    end
    q1_id = 3'd0; q2_id = 3'd1;
    #1;
    checks++;
    if (q1_ready !== 1'b0 || q1_value !== 32'd0 || q2_ready !== 1'b0 || q2_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_lookup: got %b/%h %b/%h want 0/0 0/0", q1_ready, q1_value, q2_ready, q2_value);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    idle_inputs();
    #1;
  endtask

  task automatic test_full();
    do_flush();
    for (int i = 0; i < RS; i++) issue_one(5'(i + 1), 1'b0, 32'(i));
    checks++;
    if (rob_full !== 1'b1 || rob_free_id !== 3'd0) begin
      errors++;
      $display("FAIL full_after8: got full=%b free=%0d want 1 0", rob_full, rob_free_id);
    end
    issue_one(5'd9, 1'b1, 32'h99);
    checks++;
    if (rob_full !== 1'b1 || rob_free_id !== 3'd0 || commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_ninth: got full=%b free=%0d cv=%b want 1 0 0", rob_full, rob_free_id, commit_valid);
    end
  endtask

  task automatic test_ready_issue();
    do_flush();
    issue_one(5'd5, 1'b1, 32'h1234);
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_early: got cv=%b want 0", commit_valid);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_value !== 32'h1234 || commit_rob_id !== 3'd0) begin
      errors++;
      $display("FAIL ready_commit: got v=%b rd=%0d val=%h id=%0d want 1 5 1234 0",
               commit_valid, commit_rd, commit_value, commit_rob_id);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_pulse: got cv=%b want 0", commit_valid);
    end
  endtask

  task automatic test_in_order();
    do_flush();
    issue_one(5'd1, 1'b0, 32'h0);
    issue_one(5'd2, 1'b0, 32'h0);
    cdb_valid = 1'b1; cdb_rob_id = 3'd1; cdb_value = 32'hBB;
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_no_early: got cv=%b want 0", commit_valid);
    end
    cdb_rob_id = 3'd0; cdb_value = 32'hAA;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_rob_id !== 3'd0 || commit_value !== 32'hAA || commit_rd !== 5'd1) begin
      errors++;
      $display("FAIL order_first: got v=%b id=%0d val=%h rd=%0d want 1 0 aa 1",
               commit_valid, commit_rob_id, commit_value, commit_rd);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_rob_id !== 3'd1 || commit_value !== 32'hBB || commit_rd !== 5'd2) begin
      errors++;
      $display("FAIL order_second: got v=%b id=%0d val=%h rd=%0d want 1 1 bb 2",
               commit_valid, commit_rob_id, commit_value, commit_rd);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    cdb_valid = 1'b1; cdb_rob_id = 3'd2; cdb_value = 32'h55;
    q1_id = 3'd2; q2_id = 3'd1;
    #1;
    checks++;
    if (q1_ready !== 1'b1 || q1_value !== 32'h55) begin
      errors++;
      $display("FAIL bypass_q1: got %b/%h want 1/55", q1_ready, q1_value);
    end
    checks++;
    if (q2_ready !== 1'b1 || q2_value !== 32'hBB) begin
      errors++;
      $display("FAIL bypass_q2_stale: got %b/%h want 1/bb", q2_ready, q2_value);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush_full();
    do_flush();
    for (int i = 0; i < RS; i++) issue_one(5'(i), 1'b0, 32'(i));
    flush_in = 1'b1; issue_valid = 1'b1; issue_ready = 1'b1; issue_rd = 5'd7;
    cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_value = 32'h77;
    tick();
    idle_inputs();
    checks++;
    if (rob_full !== 1'b0 || rob_free_id !== 3'd0 || commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: got full=%b free=%0d cv=%b want 0 0 0", rob_full, rob_free_id, commit_valid);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0 || rob_free_id !== 3'd0) begin
      errors++;
      $display("FAIL flush_no_commit: got cv=%b free=%0d want 0 0", commit_valid, rob_free_id);
    end
  endtask

  task automatic test_stall();
    do_flush();
    issue_one(5'd9, 1'b1, 32'hCAFE);
    for (int i = 0; i < 3; i++) begin
      rdy_in = 1'b0;
      tick();
      checks++;
      if (commit_valid !== 1'b0 || rob_free_id !== 3'd1) begin
        errors++;
        $display("FAIL stall_hold%0d: got cv=%b free=%0d want 0 1", i, commit_valid, rob_free_id);
      end
    end
    rdy_in = 1'b1;
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_value !== 32'hCAFE || commit_rob_id !== 3'd0) begin
      errors++;
      $display("FAIL stall_resume: got v=%b val=%h id=%0d want 1 cafe 0", commit_valid, commit_value, commit_rob_id);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_single: got cv=%b want 0", commit_valid);
    end
  endtask

  task automatic test_random();
    bit          ex_ready;
    logic [31:0] ex_value;
    do_flush();
    for (int n = 0; n < 400; n++) begin
      rdy_in      = ($urandom_range(0, 99) < 85);
      flush_in    = ($urandom_range(0, 99) < 3);
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = 5'($urandom);
      issue_ready = ($urandom_range(0, 2) == 0);
      issue_value = $urandom;
      cdb_valid   = ($urandom_range(0, 99) < 45);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        cdb_rob_id = RB'(mq[$urandom_range(0, mq.size() - 1)].id);
      else
        cdb_rob_id = RB'($urandom);
      cdb_value = $urandom;
      q1_id = ($urandom_range(0, 1) == 1) ? cdb_rob_id : RB'($urandom);
      q2_id = RB'($urandom);
      #1;
      checks++;
      if (rob_full !== (mq.size() == RS) || rob_free_id !== RB'(m_tail)) begin
        errors++;
        $display("FAIL rand_ptr[%0d]: got full=%b free=%0d want %b %0d",
                 n, rob_full, rob_free_id, (mq.size() == RS), m_tail);
      end
      ex_ready = (cdb_valid && cdb_rob_id == q1_id) ? 1'b1 : m_ready[q1_id];
      ex_value = (cdb_valid && cdb_rob_id == q1_id) ? cdb_value : m_value[q1_id];
      checks++;
      if (q1_ready !== ex_ready || q1_value !== ex_value) begin
        errors++;
        $display("FAIL rand_q1[%0d]: got %b/%h want %b/%h", n, q1_ready, q1_value, ex_ready, ex_value);
      end
      ex_ready = (cdb_valid && cdb_rob_id == q2_id) ? 1'b1 : m_ready[q2_id];
      ex_value = (cdb_valid && cdb_rob_id == q2_id) ? cdb_value : m_value[q2_id];
      checks++;
      if (q2_ready !== ex_ready || q2_value !== ex_value) begin
        errors++;
        $display("FAIL rand_q2[%0d]: got %b/%h want %b/%h", n, q2_ready, q2_value, ex_ready, ex_value);
      end
      tick();
      checks++;
      if (commit_valid !== e_cv) begin
        errors++;
        $display("FAIL rand_cv[%0d]: got %b want %b", n, commit_valid, e_cv);
      end else if (e_cv) begin
        checks++;
        if (commit_rd !== e_rd || commit_value !== e_val || commit_rob_id !== RB'(e_id)) begin
          errors++;
          $display("FAIL rand_cdata[%0d]: got rd=%0d val=%h id=%0d want %0d %h %0d",
                   n, commit_rd, commit_value, commit_rob_id, e_rd, e_val, e_id);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_full();
    test_ready_issue();
    test_in_order();
    test_bypass();
    test_flush_full();
    test_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
